// File: rtl/uart_pkt_arbiter.sv
// Round-robin arbiter that streams one requester's packet at a time,
// MSB byte first, into a shared UART TX FIFO with optional terminator.
module uart_pkt_arbiter #(
    parameter int          N_REQ     = 2,
    parameter int          PKT_BYTES = 22,
    parameter int          TERM_EN   = 1,
    parameter logic [7:0]  TERM_BYTE = 8'h0A
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*PKT_BYTES*8-1:0] pkt_data,
    output logic [N_REQ-1:0]             done,
    output logic [N_REQ-1:0]             grant,
    output logic                         busy,
    input  logic                         fifo_full,
    output logic                         fifo_wr,
    output logic [7:0]                   fifo_din
);

    localparam int PW = PKT_BYTES * 8;
    localparam int IW = $clog2(PKT_BYTES + 1);
    localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [RW-1:0]    rr_q, rr_d;
    logic [PW-1:0]    shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [RW-1:0]    win_idx;
    logic [N_REQ-1:0] win_oh;
    logic [PW-1:0]    win_pkt;

    // Requesters above rr_q win first; otherwise wrap to the lowest index.
    always_comb begin
        eligible = req & ~done_q;
        found    = 1'b0;
        win_idx  = '0;
        win_oh   = '0;
        win_pkt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && eligible[i] && (RW'(i) > rr_q)) begin
                found      = 1'b1;
                win_idx    = RW'(i);
                win_oh[i]  = 1'b1;
                win_pkt    = pkt_data[i*PW +: PW];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && eligible[i]) begin
                found      = 1'b1;
                win_idx    = RW'(i);
                win_oh[i]  = 1'b1;
                win_pkt    = pkt_data[i*PW +: PW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        rr_d    = rr_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = win_oh;
                    rr_d    = win_idx;
                    shift_d = win_pkt;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!fifo_full) begin
                    shift_d = shift_q << 8;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(PKT_BYTES - 1)) begin
                        if (TERM_EN != 0) begin
                            state_d = TERM;
                        end else begin
                            state_d = IDLE;
                            done_d  = grant_q;
                            grant_d = '0;
                        end
                    end
                end
            end
            TERM: begin
                if (!fifo_full) begin
                    state_d = IDLE;
                    done_d  = grant_q;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            rr_q    <= RW'(N_REQ - 1);
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        fifo_wr  = 1'b0;
        fifo_din = 8'h00;
        unique case (state_q)
            SEND: begin
                fifo_wr  = ~fifo_full;
                fifo_din = shift_q[PW-1 -: 8];
            end
            TERM: begin
                fifo_wr  = ~fifo_full;
                fifo_din = TERM_BYTE;
            end
            default: ;
        endcase
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_pkt_arbiter.sv
// Directed bench: a 2-requester instance for streaming, backpressure,
// snapshot and reset cases, and a 4-requester instance for round-robin order.
module tb_uart_pkt_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  req = '0;
    logic [47:0] pkt_data = '0;
    logic [1:0]  done;
    logic [1:0]  grant;
    logic        busy;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [7:0]  fifo_din;

    logic [3:0]  req4 = '0;
    logic [95:0] pkt_data4 = '0;
    logic [3:0]  done4;
    logic [3:0]  grant4;
    logic        busy4;
    logic        fifo_full4 = 1'b0;
    logic        fifo_wr4;
    logic [7:0]  fifo_din4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_pkt_arbiter #(
        .N_REQ(2), .PKT_BYTES(3), .TERM_EN(1), .TERM_BYTE(8'h0A)
    ) u_dut (
        .clk(clk), .rst(rst), .req(req), .pkt_data(pkt_data),
        .done(done), .grant(grant), .busy(busy),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din)
    );

    uart_pkt_arbiter #(
        .N_REQ(4), .PKT_BYTES(3), .TERM_EN(1), .TERM_BYTE(8'h0A)
    ) u_dut4 (
        .clk(clk), .rst(rst), .req(req4), .pkt_data(pkt_data4),
        .done(done4), .grant(grant4), .busy(busy4),
        .fifo_full(fifo_full4), .fifo_wr(fifo_wr4), .fifo_din(fifo_din4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        req4 = '0;
        fifo_full = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // Entered in the first byte cycle; returns in the done cycle.
    task automatic expect_pkt(input string tag, input logic [1:0] g,
                              input logic [23:0] d);
        logic [7:0] e;
        for (int b = 0; b < 4; b++) begin
            e = (b < 3) ? d[23-8*b -: 8] : 8'h0A;
            chk({tag, "_wr"}, 32'(fifo_wr), 32'd1);
            chk({tag, "_din"}, 32'(fifo_din), 32'(e));
            chk({tag, "_grant"}, 32'(grant), 32'(g));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            step();
        end
        chk({tag, "_done"}, 32'(done), 32'(g));
        chk({tag, "_gclr"}, 32'(grant), 32'd0);
        chk({tag, "_wr0"}, 32'(fifo_wr), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // reset values
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr", 32'(fifo_wr), 32'd0);
        chk("rst_din", 32'(fifo_din), 32'd0);

        // single packet, no backpressure
        pkt_data[23:0] = 24'h414243;
        req = 2'b01;
        step();
        expect_pkt("c1", 2'b01, 24'h414243);
        req = 2'b00;
        step();
        chk("c1_done_pulse", 32'(done), 32'd0);
        chk("c1_stay_idle", 32'(busy), 32'd0);

        // simultaneous requests from reset
        do_reset();
        pkt_data = {24'h222222, 24'h111111};
        req = 2'b11;
        step();
        expect_pkt("c2a", 2'b01, 24'h111111);
        req = 2'b10;
        step();
        expect_pkt("c2b", 2'b10, 24'h222222);
        req = 2'b00;
        step();
        chk("c2_idle", 32'(busy), 32'd0);

        // backpressure for 5 cycles after the second byte
        do_reset();
        pkt_data[23:0] = 24'h414243;
        req = 2'b01;
        step();
        chk("c3_b0", 32'(fifo_din), 32'h41);
        step();
        chk("c3_b1", 32'(fifo_din), 32'h42);
        chk("c3_b1wr", 32'(fifo_wr), 32'd1);
        step();
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("c3_stall_wr", 32'(fifo_wr), 32'd0);
            chk("c3_stall_din", 32'(fifo_din), 32'h43);
            chk("c3_stall_busy", 32'(busy), 32'd1);
            step();
        end
        fifo_full = 1'b0;
        #1;
        chk("c3_b2wr", 32'(fifo_wr), 32'd1);
        chk("c3_b2", 32'(fifo_din), 32'h43);
        step();
        chk("c3_term", 32'(fifo_din), 32'h0A);
        chk("c3_termwr", 32'(fifo_wr), 32'd1);
        step();
        chk("c3_done", 32'(done), 32'd1);
        chk("c3_wr0", 32'(fifo_wr), 32'd0);
        req = 2'b00;

        // snapshot: request and data change after grant
        do_reset();
        pkt_data[23:0] = 24'h414243;
        req = 2'b01;
        step();
        req = 2'b00;
        pkt_data[23:0] = 24'hDEADBE;
        expect_pkt("c4", 2'b01, 24'h414243);
        step();
        chk("c4_no_regrant", 32'(grant), 32'd0);

        // reset during the second byte
        do_reset();
        pkt_data = {24'h313233, 24'h414243};
        req = 2'b01;
        step();
        chk("c5_b0", 32'(fifo_din), 32'h41);
        step();
        chk("c5_b1", 32'(fifo_din), 32'h42);
        rst = 1'b1;
        req = 2'b10;
        step();
        rst = 1'b0;
        chk("c5_grant", 32'(grant), 32'd0);
        chk("c5_busy", 32'(busy), 32'd0);
        chk("c5_wr", 32'(fifo_wr), 32'd0);
        chk("c5_din", 32'(fifo_din), 32'd0);
        chk("c5_done", 32'(done), 32'd0);
        step();
        expect_pkt("c5", 2'b10, 24'h313233);
        req = 2'b00;

        // four requesters held high: strict rotation
        do_reset();
        for (int i = 0; i < 4; i++)
            pkt_data4[i*24 +: 24] = {3{8'(160 + i)}};
        req4 = 4'hF;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("c6_grant", 32'(grant4), 32'(4'b0001 << (k % 4)));
            chk("c6_din", 32'(fifo_din4), 32'(160 + (k % 4)));
            chk("c6_wr", 32'(fifo_wr4), 32'd1);
            repeat (4) step();
            chk("c6_done", 32'(done4), 32'(4'b0001 << (k % 4)));
            req4 = 4'hF & ~(4'b0001 << (k % 4));
            step();
            req4 = 4'hF;
        end
        req4 = 4'h0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
